ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends single command/argument bytes to the keyboard, e.g. 0xFF reset, 0xED set LEDs, 0xF4 enable.
- Sits beside the PS/2 receive path on the same two open-drain lines. Drives each line only by a pull-low enable.
- Reports a done pulse on device ACK, or an error pulse on timeout or missing ACK.
- Asserts busy so the top level can discard receive-side activity during a transmission.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency used to derive all timers.
- INHIBIT_US, 120, time the clock is held low before the request-to-send (≥100 µs required).
- START_TIMEOUT_US, 15000, maximum wait from clock release to the first device falling edge.
- XFER_TIMEOUT_US, 2000, maximum time from the first falling edge to ACK sampling.
- FILTER_CYCLES, 8, consecutive equal samples required before a synchronized line level is accepted.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ps2_clk_in  in  1  raw PS/2 clock line level (asynchronous).
- ps2_data_in  in  1  raw PS/2 data line level (asynchronous).
- ps2_clk_drive_low  out  1  1 = pull the clock line low; 0 = release (high-Z).
- ps2_data_drive_low  out  1  1 = pull the data line low; 0 = release.
- tx_data  in  8  byte to send.
- tx_valid  in  1  request; a byte is accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse when a transfer completes with ACK.
- tx_error  out  1  one-cycle pulse on timeout or NACK.

Behaviour:
- Reset values: both drive_low outputs 0, tx_ready 1, busy 0, tx_done 0, tx_error 0, state IDLE, all counters 0.
- Reset asserted mid-transfer releases both lines on the next clk edge. No pulse is emitted.
- Input conditioning: each line passes through a 2-FF synchronizer, then a FILTER_CYCLES stability filter. A falling edge is a filtered 1→0 transition, registered as a one-cycle strobe.
- Parity: odd parity, parity = ~^tx_data, latched at accept.
- tx_valid while busy is ignored. No queueing.
- IDLE: tx_ready=1. On accept, latch data and parity, go to INHIBIT.
- INHIBIT: clock pulled low, data released, for INHIBIT_US×CLK_FREQ_HZ/1e6 cycles. Then go to RTS.
- RTS: pull data low for exactly 1 cycle while the clock is still held low. Then go to WAIT_CLK.
- WAIT_CLK: release the clock; keep data low (start bit). Arm the start timer.
  - First falling edge: go to SHIFT with bit_cnt=0, drive bit0, arm the transfer timer.
  - Start timer expiry: go to ERROR.
- SHIFT: on each falling edge, present the next bit (drive_low = ~bit).
  - Edges 1–8 present data bits LSB first.
  - Edge 9 presents parity.
  - Edge 10 releases data (stop bit) and goes to ACK.
  - bit_cnt is 4 bits and must not wrap.
- ACK: on edge 11, sample filtered data.
  - 0 = ACK: go to WAIT_IDLE.
  - 1 = NACK: go to ERROR.
- WAIT_IDLE: wait until filtered clock and data are both 1. Then pulse tx_done and return to IDLE.
- The transfer timer runs from SHIFT through WAIT_IDLE. Expiry in any of these states goes to ERROR.
- ERROR: release both lines, pulse tx_error for 1 cycle, return to IDLE.
- At most one of tx_done / tx_error fires per accepted byte, exactly once.
- Timers: a single down-counter sized $clog2 of the largest cycle count. It is reloaded on every state entry that arms it.

Decomposition:
- ps2_pkg holds:
  - state enum (IDLE, INHIBIT, RTS, WAIT_CLK, SHIFT, ACK, WAIT_IDLE, ERROR);
  - command constants PS2_CMD_RESET=8'hFF, PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_RESP_ACK=8'hFA;
  - a us_to_cycles constant function.
- Sub-module ps2_line_sync: synchronizer plus filter plus falling-edge strobe, instantiated once per line. It is reusable by the receive path.

Test Plan (device BFM clocks at 12.5 kHz; CLK_FREQ_HZ=1_000_000 to shorten sim):
- Send 0xED, BFM ACKs → BFM captures bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; tx_error stays 0; clock held low ≥120 µs before RTS.
- Send 0xF4 then 0x00 back-to-back → parity 0 and 1 respectively; tx_ready low between transfers; two tx_done pulses.
- BFM never clocks → tx_error pulses 15000 cycles after clock release; both drive_low are 0 afterwards.
- BFM stops after 5 clocks → tx_error at 2000 cycles after the first edge.
- BFM NACKs (data high on edge 11) for 0xFF → tx_error, no tx_done.
- rst asserted during SHIFT → next cycle both lines released, tx_ready=1, no pulses. Inject 2-cycle glitches on ps2_clk_in → no spurious bit advance.

Source files
------------

// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
// Shared PS/2 types: transmitter state encoding, common keyboard command bytes, timer helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    WAIT_CLK,
    SHIFT,
    ACK,
    WAIT_IDLE,
    ERROR
  } ps2_state_t;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  // Widened to 64 bits so long timeouts at high clock rates do not overflow.
  function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned freq_hz);
    return 32'((64'(us) * 64'(freq_hz)) / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
`timescale 1ns/1ps
// Byte request / status bundle between a command issuer (master) and the PS/2 transmitter (slave).
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (output tx_data, tx_valid, input tx_ready, busy, tx_done, tx_error);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, tx_done, tx_error);
endinterface

// File: rtl/ps2_line_sync.sv
`timescale 1ns/1ps
// One PS/2 line: 2-FF synchronizer, stability filter and registered falling-edge strobe.
// Lines idle high, so the synchronizer and filtered level come out of reset at 1.
module ps2_line_sync #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fall
);
  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      meta <= line;
      sync <= meta;
      fall <= 1'b0;
      // Level moves only after FILTER_CYCLES consecutive samples disagree with it.
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
        level <= sync;
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, clocked shift-out, ACK check.
// Lines are driven only as pull-low enables; busy spans the whole transfer so receive activity can be discarded.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
  parameter int unsigned INHIBIT_US       = 120,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned XFER_TIMEOUT_US  = 2000,
  parameter int          FILTER_CYCLES    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_drive_low,
  output logic         ps2_data_drive_low,
  ps2_host_tx_if.slave tx
);
  localparam int unsigned INHIBIT_CYC = us_to_cycles(INHIBIT_US, CLK_FREQ_HZ);
  localparam int unsigned START_CYC   = us_to_cycles(START_TIMEOUT_US, CLK_FREQ_HZ);
  localparam int unsigned XFER_CYC    = us_to_cycles(XFER_TIMEOUT_US, CLK_FREQ_HZ);
  localparam int unsigned MAX_CYC =
    (INHIBIT_CYC > START_CYC) ? ((INHIBIT_CYC > XFER_CYC) ? INHIBIT_CYC : XFER_CYC)
                              : ((START_CYC > XFER_CYC) ? START_CYC : XFER_CYC);
  localparam int TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] INHIBIT_LOAD = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] START_LOAD   = TW'(START_CYC - 1);
  localparam logic [TW-1:0] XFER_LOAD    = TW'(XFER_CYC - 1);

  ps2_state_t    state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    data_q;
  logic          parity_q;
  logic          clk_lvl, clk_fall, data_lvl, data_fall_unused;
  logic          clk_low, data_low, ready, done, error, expired, cur_bit, accept;

  ps2_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_sync (
    .clk(clk), .rst(rst), .line(ps2_clk_in), .level(clk_lvl), .fall(clk_fall)
  );
  ps2_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_sync (
    .clk(clk), .rst(rst), .line(ps2_data_in), .level(data_lvl), .fall(data_fall_unused)
  );

  assign accept  = (state == IDLE) && tx.tx_valid;
  assign expired = (timer == '0);
  assign cur_bit = bit_cnt[3] ? parity_q : data_q[bit_cnt[2:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_cnt <= bit_cnt_n;
      if (accept) begin
        data_q   <= tx.tx_data;
        parity_q <= ~^tx.tx_data;
      end
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_cnt_n = bit_cnt;
    clk_low   = 1'b0;
    data_low  = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (tx.tx_valid) begin
          state_n = INHIBIT;
          timer_n = INHIBIT_LOAD;
        end
      end
      INHIBIT: begin
        clk_low = 1'b1;
        if (expired) state_n = RTS;
        else         timer_n = timer - TW'(1);
      end
      RTS: begin
        clk_low  = 1'b1;
        data_low = 1'b1;
        state_n  = WAIT_CLK;
        timer_n  = START_LOAD;
      end
      WAIT_CLK: begin
        data_low = 1'b1;
        if (clk_fall) begin
          state_n   = SHIFT;
          bit_cnt_n = '0;
          timer_n   = XFER_LOAD;
        end else if (expired) begin
          state_n = ERROR;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      // bit_cnt 0..7 selects data LSB first, 8 selects parity; the edge after parity is the stop bit.
      SHIFT: begin
        data_low = ~cur_bit;
        if (expired) begin
          state_n = ERROR;
        end else begin
          timer_n = timer - TW'(1);
          if (clk_fall) begin
            if (bit_cnt == 4'd8) state_n = ACK;
            else                 bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      ACK: begin
        if (expired) begin
          state_n = ERROR;
        end else begin
          timer_n = timer - TW'(1);
          if (clk_fall) state_n = data_lvl ? ERROR : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_lvl && data_lvl) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if (expired) begin
          state_n = ERROR;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      ERROR: begin
        error   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign ps2_clk_drive_low  = clk_low;
  assign ps2_data_drive_low = data_low;
  assign tx.tx_ready        = ready;
  assign tx.busy            = (state != IDLE);
  assign tx.tx_done         = done;
  assign tx.tx_error        = error;
endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Randomized PS/2 host-transmit bench: device BFM on wired-AND lines, expectation queue and pulse monitor.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 120;
  localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2, M_STOP5 = 3, M_ABORT = 4;

  typedef struct {
    logic [7:0] data;
    bit         err;
    bit         has_frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch_low = 1'b0;
  logic clk_drv, data_drv, clk_line, data_line;

  exp_t       exp_q[$];
  logic [9:0] frame_q[$];
  int tests = 0, fails = 0;
  int issued = 0, resp_cnt = 0, done_cnt = 0, err_cnt = 0, exp_done = 0;
  int inh_run = 0, inh_last = 0;
  longint cyc = 0, rel_cyc = 0, edge_cyc = 0, last_err_cyc = 0;

  ps2_host_tx_if tx_if();

  assign clk_line  = ~(clk_drv | dev_clk_low | glitch_low);
  assign data_line = ~(data_drv | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ(1_000_000), .INHIBIT_US(120), .START_TIMEOUT_US(15000),
    .XFER_TIMEOUT_US(2000), .FILTER_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .ps2_clk_drive_low(clk_drv), .ps2_data_drive_low(data_drv), .tx(tx_if)
  );

  initial forever #500 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Line order as the device sees it: 8 data bits LSB first, odd parity, stop.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    bit p;
    p = ($countones(d) % 2) == 0;
    return {1'b1, p, d};
  endfunction

  initial forever begin
    @(negedge clk);
    if (clk_drv && !data_drv) inh_run++;
    else begin
      if (clk_drv && data_drv && inh_run > 0) inh_last = inh_run;
      inh_run = 0;
    end
  end

  initial begin : monitor
    exp_t e;
    logic [9:0] fr;
    forever begin
      @(negedge clk);
      if (!rst && (tx_if.tx_done || tx_if.tx_error)) begin
        if (tx_if.tx_done) done_cnt++;
        if (tx_if.tx_error) begin
          err_cnt++;
          last_err_cyc = cyc;
        end
        resp_cnt++;
        check("single_pulse", !(tx_if.tx_done && tx_if.tx_error),
              int'(tx_if.tx_done) + int'(tx_if.tx_error), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1'b0, resp_cnt, issued);
        end else begin
          e = exp_q.pop_front();
          check("resp_is_error", tx_if.tx_error == e.err, tx_if.tx_error, e.err);
          if (tx_if.tx_error)
            check("lines_released", !clk_drv && !data_drv, {clk_drv, data_drv}, 0);
          if (e.has_frame) begin
            if (frame_q.size() == 0) check("frame_missing", 1'b0, 0, 1);
            else begin
              fr = frame_q.pop_front();
              check("frame", fr == model_frame(e.data), fr, model_frame(e.data));
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input int mode, input bit push);
    bit ok;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = tx_if.tx_ready;
    end
    check("ready_before_send", ok, ok, 1);
    if (!ok) return;
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    if (push) begin
      e.data = d;
      e.err = (mode != M_ACK);
      e.has_frame = (mode == M_ACK) || (mode == M_NACK);
      exp_q.push_back(e);
      issued++;
    end
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    // A request while busy must be dropped, not queued.
    repeat (20) @(negedge clk);
    tx_if.tx_data  = ~d;
    tx_if.tx_valid = 1'b1;
    repeat (5) @(negedge clk);
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic bfm(input int mode, input bit glitch);
    bit ok;
    int n;
    logic [9:0] fr;
    ok = 1'b0;
    fr = '0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = (data_line == 1'b0) && (clk_line == 1'b1);
    end
    check("rts_seen", ok, ok, 1);
    if (!ok) return;
    rel_cyc = cyc;
    check("inhibit_cycles", inh_last >= INH && inh_last <= INH + 1, inh_last, INH);
    check("ready_low_while_busy", !tx_if.tx_ready && tx_if.busy, {tx_if.tx_ready, tx_if.busy}, 1);
    if (mode == M_SILENT) return;
    repeat (30 + $urandom_range(0, 40)) @(negedge clk);
    n = (mode == M_STOP5) ? 5 : (mode == M_ABORT) ? 3 : 11;
    for (int k = 1; k <= n; k++) begin
      dev_clk_low = 1'b1;
      if (k == 1) edge_cyc = cyc;
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b0;
      if (glitch) begin
        repeat (5) @(negedge clk);
        glitch_low = 1'b1;
        repeat (2) @(negedge clk);
        glitch_low = 1'b0;
        repeat (13) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      if (k <= 10) fr[k-1] = data_line;
      if (k == 10) begin
        frame_q.push_back(fr);
        if (mode == M_ACK) dev_data_low = 1'b1;
      end
      repeat (20) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_resp(input int budget);
    int i;
    i = 0;
    while (resp_cnt < issued && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("resp_in_time", resp_cnt >= issued, resp_cnt, issued);
  endtask

  task automatic xfer(input logic [7:0] d, input int mode, input bit glitch, input int budget);
    if (mode == M_ACK) exp_done++;
    fork
      send(d, mode, mode != M_ABORT);
      bfm(mode, glitch);
    join
    if (mode != M_ABORT) wait_resp(budget);
  endtask

  initial begin
    int d0, e0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_clk_drive", clk_drv == 1'b0, clk_drv, 0);
    check("rst_data_drive", data_drv == 1'b0, data_drv, 0);
    check("rst_ready", tx_if.tx_ready == 1'b1, tx_if.tx_ready, 1);
    check("rst_busy", tx_if.busy == 1'b0, tx_if.busy, 0);
    check("rst_pulses", !tx_if.tx_done && !tx_if.tx_error, {tx_if.tx_done, tx_if.tx_error}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    xfer(PS2_CMD_SET_LEDS, M_ACK, 1'b0, 3000);
    xfer(PS2_CMD_ENABLE, M_ACK, 1'b1, 3000);
    xfer(8'h00, M_ACK, 1'b0, 3000);

    xfer(8'h3C, M_SILENT, 1'b0, 16000);
    check("start_timeout", (last_err_cyc - rel_cyc) >= 15000 && (last_err_cyc - rel_cyc) <= 15002,
          last_err_cyc - rel_cyc, 15000);

    xfer(8'h5A, M_STOP5, 1'b0, 3000);
    check("xfer_timeout", (last_err_cyc - edge_cyc) >= 2000 && (last_err_cyc - edge_cyc) <= 2030,
          last_err_cyc - edge_cyc, 2000);

    xfer(PS2_CMD_RESET, M_NACK, 1'b0, 3000);

    xfer(8'hA5, M_ABORT, 1'b0, 0);
    check("busy_in_shift", tx_if.busy == 1'b1, tx_if.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_release", !clk_drv && !data_drv && tx_if.tx_ready && !tx_if.busy,
          {clk_drv, data_drv, tx_if.tx_ready, tx_if.busy}, 2);
    rst = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    repeat (2500) @(negedge clk);
    check("no_pulse_after_rst", done_cnt == d0 && err_cnt == e0, done_cnt + err_cnt, d0 + e0);

    xfer(PS2_RESP_ACK, M_ACK, 1'b1, 3000);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      int m;
      d = 8'($urandom);
      m = ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK;
      xfer(d, m, 1'($urandom_range(0, 1)), 3000);
    end

    repeat (50) @(negedge clk);
    check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    check("done_count", done_cnt == exp_done, done_cnt, exp_done);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
